// File: rtl/exe_stage_ctrl.sv
// Execute-stage controller: captures one decoded instruction, runs it through a
// variable-latency ALU, then resolves bypass, PC redirect and memory-stage FIFO push.
module exe_stage_ctrl #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int OUT_DEPTH  = 2,
    parameter int OUT_ALL    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pause,
    input  logic                  i_flush,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [XLEN-1:0]       i_in_pc,
    input  logic [6:0]            i_in_opcode,
    input  logic [2:0]            i_in_funct3,
    input  logic [6:0]            i_in_funct7,
    input  logic [XLEN-1:0]       i_in_rs1,
    input  logic [XLEN-1:0]       i_in_rs2,
    input  logic [XLEN-1:0]       i_in_imm,
    input  logic [REG_ADDR_W-1:0] i_in_rd,
    output logic                  o_alu_req_valid,
    input  logic                  i_alu_req_ready,
    output logic [3:0]            o_alu_op,
    output logic [XLEN-1:0]       o_alu_a,
    output logic [XLEN-1:0]       o_alu_b,
    input  logic                  i_alu_resp_valid,
    input  logic [XLEN-1:0]       i_alu_result,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [6:0]            o_out_opcode,
    output logic [2:0]            o_out_funct3,
    output logic [XLEN-1:0]       o_out_rs2,
    output logic [REG_ADDR_W-1:0] o_out_rd,
    output logic [XLEN-1:0]       o_out_result,
    output logic                  o_fwd_valid,
    output logic [REG_ADDR_W-1:0] o_fwd_rd,
    output logic [XLEN-1:0]       o_fwd_data,
    output logic                  o_redir_valid,
    output logic [XLEN-1:0]       o_redir_pc
);
    // state | meaning
    // IDLE  | ready to capture a new instruction
    // REQ   | ALU request presented (withheld while paused)
    // WAIT  | request accepted, waiting for the ALU response
    // DRAIN | flushed while in flight, swallow the pending response
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F, OPC_JALR = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63, OPC_LOAD = 7'h03, OPC_STORE = 7'h23;
    localparam logic [6:0] OPC_IMM = 7'h13, OPC_OP = 7'h33;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int EW = 7 + 3 + XLEN + REG_ADDR_W + XLEN;

    state_t                r_state;
    logic [XLEN-1:0]       r_pc, r_rs1, r_rs2, r_imm;
    logic [6:0]            r_opcode, r_funct7;
    logic [2:0]            r_funct3;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_fwd_valid, r_redir_valid;
    logic [REG_ADDR_W-1:0] r_fwd_rd;
    logic [XLEN-1:0]       r_fwd_data, r_redir_pc;

    logic [EW-1:0]         r_mem [OUT_DEPTH];
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [CW-1:0]         r_count;

    logic                  w_in_ready, w_alt, w_is_jump, w_taken, w_resolve, w_push, w_pop;
    logic                  w_fwd_en, w_redir_en;
    logic [XLEN-1:0]       w_link, w_redir_pc, w_push_result;

    function automatic logic [3:0] f_arith(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0:    return (alt && is_r) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_alt = (r_funct7 & 7'b0100000) != 7'd0;

    // Operands come only from captured registers so they stay stable across REQ/WAIT.
    always_comb begin
        o_alu_op = ALU_ADD;
        o_alu_a  = r_rs1;
        o_alu_b  = r_imm;
        case (r_opcode)
            OPC_OP: begin
                o_alu_b  = r_rs2;
                o_alu_op = f_arith(r_funct3, w_alt, 1'b1);
            end
            OPC_IMM:            o_alu_op = f_arith(r_funct3, w_alt, 1'b0);
            OPC_LUI:            o_alu_a  = '0;
            OPC_AUIPC, OPC_JAL: o_alu_a  = r_pc;
            OPC_BRANCH: begin
                o_alu_b = r_rs2;
                case (r_funct3[2:1])
                    2'b10:   o_alu_op = ALU_SLT;
                    2'b11:   o_alu_op = ALU_SLTU;
                    default: o_alu_op = ALU_SUB;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        case (r_funct3)
            3'd0:       w_taken = (i_alu_result == '0);
            3'd1:       w_taken = (i_alu_result != '0);
            3'd4, 3'd6: w_taken = i_alu_result[0];
            3'd5, 3'd7: w_taken = !i_alu_result[0];
            default:    w_taken = 1'b0;
        endcase
    end

    assign w_is_jump  = (r_opcode == OPC_JAL) || (r_opcode == OPC_JALR);
    assign w_link     = r_pc + XLEN'(4);
    assign w_resolve  = (r_state == S_WAIT) && i_alu_resp_valid && !i_flush;
    assign w_fwd_en   = (r_rd != '0) && (w_is_jump || r_opcode == OPC_OP || r_opcode == OPC_IMM ||
                                         r_opcode == OPC_LUI || r_opcode == OPC_AUIPC);
    assign w_redir_en = w_is_jump || ((r_opcode == OPC_BRANCH) && w_taken);
    assign w_redir_pc = (r_opcode == OPC_JAL)  ? i_alu_result :
                        (r_opcode == OPC_JALR) ? {i_alu_result[XLEN-1:1], 1'b0} : r_pc + r_imm;
    assign w_push     = w_resolve && ((OUT_ALL != 0) || r_opcode == OPC_LOAD || r_opcode == OPC_STORE);
    assign w_push_result = w_is_jump ? w_link : i_alu_result;
    assign w_pop      = (r_count != '0) && i_out_ready;

    assign w_in_ready = (r_state == S_IDLE) && !i_pause && !i_flush && (r_count < CW'(OUT_DEPTH));
    assign o_in_ready = w_in_ready;
    assign o_alu_req_valid = (r_state == S_REQ) && !i_pause && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_opcode      <= '0;
            r_funct3      <= '0;
            r_funct7      <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_imm         <= '0;
            r_rd          <= '0;
            r_fwd_valid   <= 1'b0;
            r_fwd_rd      <= '0;
            r_fwd_data    <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
        end else begin
            r_fwd_valid   <= 1'b0;
            r_redir_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_in_valid && w_in_ready) begin
                    r_pc     <= i_in_pc;
                    r_opcode <= i_in_opcode;
                    r_funct3 <= i_in_funct3;
                    r_funct7 <= i_in_funct7;
                    r_rs1    <= i_in_rs1;
                    r_rs2    <= i_in_rs2;
                    r_imm    <= i_in_imm;
                    r_rd     <= i_in_rd;
                    r_state  <= S_REQ;
                end
                S_REQ: begin
                    if (i_flush)                          r_state <= S_IDLE;
                    else if (!i_pause && i_alu_req_ready) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_flush) begin
                        r_state <= i_alu_resp_valid ? S_IDLE : S_DRAIN;
                    end else if (i_alu_resp_valid) begin
                        r_state <= S_IDLE;
                        if (w_fwd_en) begin
                            r_fwd_valid <= 1'b1;
                            r_fwd_rd    <= r_rd;
                            r_fwd_data  <= w_is_jump ? w_link : i_alu_result;
                        end
                        if (w_redir_en) begin
                            r_redir_valid <= 1'b1;
                            r_redir_pc    <= w_redir_pc;
                        end
                    end
                end
                S_DRAIN: if (i_alu_resp_valid) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {r_opcode, r_funct3, r_rs2, r_rd, w_push_result};
                r_wptr        <= f_next(r_wptr);
            end
            if (w_pop) r_rptr <= f_next(r_rptr);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
        end
    end

    assign o_out_valid = (r_count != '0);
    assign {o_out_opcode, o_out_funct3, o_out_rs2, o_out_rd, o_out_result} = r_mem[r_rptr];
    assign o_fwd_valid   = r_fwd_valid;
    assign o_fwd_rd      = r_fwd_rd;
    assign o_fwd_data    = r_fwd_data;
    assign o_redir_valid = r_redir_valid;
    assign o_redir_pc    = r_redir_pc;
endmodule
